// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared widths, FSM state encoding and transaction record for
//               the instruction/data cache to main-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Block address and block data widths of the shared main memory
  localparam int c_ADDR_W  = 6;
  localparam int c_DATA_W  = 32;
  localparam int c_STATE_W = 3;

  // Arbiter FSM state encoding
  typedef logic [c_STATE_W-1:0] arb_state_t;

  localparam arb_state_t c_IDLE   = 3'd0;
  localparam arb_state_t c_D_REQ  = 3'd1;
  localparam arb_state_t c_D_RESP = 3'd2;
  localparam arb_state_t c_I_REQ  = 3'd3;
  localparam arb_state_t c_I_RESP = 3'd4;

  // Requesting side, used for the last-served pointer
  typedef enum logic {
    SIDE_D = 1'b0,
    SIDE_I = 1'b1
  } side_e;

  // Request captured at grant time; memory outputs are driven only from this
  typedef struct packed {
    logic                write;
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
  } mem_txn_t;

  // True while a memory transaction is being presented to main memory
  function automatic logic is_req_state(input arb_state_t s);
    return (s == c_D_REQ) || (s == c_I_REQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates instruction-cache block reads and data-cache block
//               reads/write-backs onto one shared main memory. One memory
//               transaction is in flight at a time; the grant is taken in
//               IDLE and the request is latched so memory never sees the
//               caches' live inputs.
//               Optional build macro MEM_ARB_ROUND_ROBIN_EN: when both sides
//               request in IDLE, grant the side not served last. Undefined:
//               fixed priority, data side over instruction side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  // Instruction cache side
  input  logic                I_READ,
  input  logic [c_ADDR_W-1:0] I_ADDRESS,
  output logic [c_DATA_W-1:0] I_READDATA,
  output logic                I_BUSYWAIT,
  // Data cache side
  input  logic                D_READ,
  input  logic                D_WRITE,
  input  logic [c_ADDR_W-1:0] D_ADDRESS,
  input  logic [c_DATA_W-1:0] D_WRITEDATA,
  output logic [c_DATA_W-1:0] D_READDATA,
  output logic                D_BUSYWAIT,
  // Shared main memory
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic [c_ADDR_W-1:0] MEM_ADDRESS,
  output logic [c_DATA_W-1:0] MEM_WRITEDATA,
  input  logic [c_DATA_W-1:0] MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic                r_seen_busy;
  mem_txn_t            r_txn;
  logic [c_DATA_W-1:0] r_i_readdata;
  logic [c_DATA_W-1:0] r_d_readdata;

  logic w_d_pend;
  logic w_i_pend;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_req;
  logic w_mem_done;

  assign w_d_pend = D_READ | D_WRITE;
  assign w_i_pend = I_READ;
  assign w_in_req = is_req_state(r_state);

  // Memory has finished only once it has actually stalled us and then released
  assign w_mem_done = r_seen_busy & ~MEM_BUSYWAIT;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  side_e r_last_served;

  // Instruction side wins if it is alone, or if both ask and data went last
  assign w_grant_i = w_i_pend & (~w_d_pend | (r_last_served == SIDE_D));

  // Last-served pointer; reset value makes the data side win the first tie
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last_served <= SIDE_I;
    end else if (r_state == c_D_RESP) begin
      r_last_served <= SIDE_D;
    end else if (r_state == c_I_RESP) begin
      r_last_served <= SIDE_I;
    end
  end
`else
  // Fixed priority: instruction side only when the data side is quiet
  assign w_grant_i = w_i_pend & ~w_d_pend;
`endif

  assign w_grant_d = w_d_pend & ~w_grant_i;

  // Next-state logic for the grant / request / response sequence
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant_d) begin
          w_next_state = c_D_REQ;
        end else if (w_grant_i) begin
          w_next_state = c_I_REQ;
        end
      end
      c_D_REQ: begin
        if (w_mem_done) begin
          w_next_state = c_D_RESP;
        end
      end
      c_I_REQ: begin
        if (w_mem_done) begin
          w_next_state = c_I_RESP;
        end
      end
      c_D_RESP: w_next_state = c_IDLE;
      c_I_RESP: w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winner's request on the grant edge; a read-plus-write is a write
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_txn <= '0;
    end else if (r_state == c_IDLE) begin
      if (w_grant_d) begin
        r_txn <= '{write: D_WRITE, addr: D_ADDRESS, wdata: D_WRITEDATA};
      end else if (w_grant_i) begin
        r_txn <= '{write: 1'b0, addr: I_ADDRESS, wdata: '0};
      end
    end
  end

  // Remember that memory has stalled during this request; clear entering IDLE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_seen_busy <= 1'b0;
    end else if (w_in_req && MEM_BUSYWAIT) begin
      r_seen_busy <= 1'b1;
    end else if ((r_state == c_D_RESP) || (r_state == c_I_RESP)) begin
      r_seen_busy <= 1'b0;
    end
  end

  // Capture returned data for the winning side; held until that side's next capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_i_readdata <= '0;
      r_d_readdata <= '0;
    end else if (w_mem_done) begin
      if (r_state == c_D_REQ) begin
        r_d_readdata <= MEM_READDATA;
      end
      if (r_state == c_I_REQ) begin
        r_i_readdata <= MEM_READDATA;
      end
    end
  end

  assign I_READDATA = r_i_readdata;
  assign D_READDATA = r_d_readdata;

  // A side stalls while it requests, except in its own one-cycle response
  assign I_BUSYWAIT = I_READ   & (r_state != c_I_RESP);
  assign D_BUSYWAIT = w_d_pend & (r_state != c_D_RESP);

  // Memory sees only latched values, and only while a request is outstanding
  assign MEM_READ      = w_in_req & ~r_txn.write;
  assign MEM_WRITE     = w_in_req &  r_txn.write;
  assign MEM_ADDRESS   = w_in_req ? r_txn.addr  : '0;
  assign MEM_WRITEDATA = w_in_req ? r_txn.wdata : '0;

endmodule

`default_nettype wire
